keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl_if.sv | 14 +
 rtl/keypad_entry_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: key code in, completed BCD entry out with valid/ready handshake and status pulses
interface keypad_entry_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [3:0]          key_code;
    logic [4*DIGITS-1:0] entry_data;
    logic                entry_valid;
    logic                entry_ready;
    logic [3:0]          digit_cnt;
    logic                err;
    logic                timeout;
    modport master (output key_code, entry_ready, input entry_data, entry_valid, digit_cnt, err, timeout);
    modport slave  (input key_code, entry_ready, output entry_data, entry_valid, digit_cnt, err, timeout);
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounced keypad digit entry with handshake output; optional inactivity clear under KEYPAD_TIMEOUT_EN
module keypad_entry_ctrl #(
    parameter int DIGITS      = 4,
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    keypad_entry_ctrl_if.slave kp
);
    localparam int          DW          = 4 * DIGITS;
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYC - 1);
    localparam logic [3:0]  DIGITS_MAX  = 4'(DIGITS);
    localparam logic [3:0]  KEY_NONE    = 4'hF;
    localparam logic [3:0]  KEY_CLEAR   = 4'hA;
    localparam logic [3:0]  KEY_ZERO    = 4'hB;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} deb_state_e;
    typedef enum logic {COLLECT, SEND} ent_state_e;

    deb_state_e    deb_q, deb_d;
    ent_state_e    ent_q, ent_d;
    logic [3:0]    key;
    logic [3:0]    cand_q, cand_d;
    logic [15:0]   stab_q, stab_d, stab_inc;
    logic          press_q, press_d;
    logic [DW-1:0] data_q, data_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          xfer;
    logic          is_digit;
    logic [3:0]    digit;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("keypad_entry_ctrl: DIGITS must be 1..8");
    end
    if (STABLE_CYC < 2 || STABLE_CYC > 65535) begin : g_bad_stable
        $error("keypad_entry_ctrl: STABLE_CYC must be 2..65535");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("keypad_entry_ctrl: TIMEOUT_CYC must be positive");
    end

    // Unassigned scanner codes behave exactly like "no key"
    assign key      = (kp.key_code >= 4'h1 && kp.key_code <= 4'hC) ? kp.key_code : KEY_NONE;
    assign stab_inc = stab_q + 16'd1;
    assign xfer     = ent_q == SEND && kp.entry_ready;
    assign is_digit = cand_q <= 4'h9 || cand_q == KEY_ZERO;
    assign digit    = cand_q == KEY_ZERO ? 4'h0 : cand_q;

    // Debounce: qualify a stable code as one press, then require a stable release before re-arming
    always_comb begin
        deb_d   = deb_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        press_d = 1'b0;
        case (deb_q)
            IDLE: begin
                if (key != KEY_NONE) begin
                    deb_d  = PRESS_WAIT;
                    cand_d = key;
                    stab_d = '0;
                end
            end
            PRESS_WAIT: begin
                stab_d = stab_inc;
                if (key != cand_q) begin
                    deb_d = IDLE;
                end else if (stab_inc == STABLE_LAST) begin
                    deb_d   = HELD;
                    press_d = 1'b1;
                end
            end
            HELD: begin
                if (key == KEY_NONE) begin
                    deb_d  = REL_WAIT;
                    stab_d = '0;
                end
            end
            REL_WAIT: begin
                stab_d = stab_inc;
                if (key != KEY_NONE) deb_d = HELD;
                else if (stab_inc == STABLE_LAST) deb_d = IDLE;
            end
            default: deb_d = IDLE;
        endcase
    end

`ifdef KEYPAD_TIMEOUT_EN
    localparam int            TW           = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          idle_run;
    logic          tmo_q, tmo_d;

    // The timer only runs on a partial entry and restarts on any press
    assign idle_run = ent_q == COLLECT && cnt_q != '0 && !press_q;
    assign idle_d   = (!idle_run || idle_q == TIMEOUT_LAST) ? '0 : idle_q + TW'(1);

    // Inactivity timer and its timeout pulse register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= tmo_d;
        end
    end

    assign kp.timeout = tmo_q;
`else
    assign kp.timeout = 1'b0;
`endif

    // Entry: buffer digits, hand off on enter; a transfer outranks a same-cycle press
    always_comb begin
        ent_d  = ent_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
        tmo_d  = 1'b0;
`endif
        if (xfer) begin
            ent_d  = COLLECT;
            data_d = '0;
            cnt_d  = '0;
        end else if (press_q && ent_q == COLLECT) begin
            if (is_digit) begin
                if (cnt_q == DIGITS_MAX) begin
                    err_d = 1'b1;
                end else begin
                    data_d = (data_q << 4) | DW'(digit);
                    cnt_d  = cnt_q + 4'd1;
                end
            end else if (cand_q == KEY_CLEAR) begin
                data_d = '0;
                cnt_d  = '0;
            end else if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                ent_d = SEND;
            end
        end
`ifdef KEYPAD_TIMEOUT_EN
        else if (idle_run && idle_q == TIMEOUT_LAST) begin
            data_d = '0;
            cnt_d  = '0;
            tmo_d  = 1'b1;
        end
`endif
    end

    // State, buffer and status registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            deb_q   <= IDLE;
            cand_q  <= KEY_NONE;
            stab_q  <= '0;
            press_q <= 1'b0;
            ent_q   <= COLLECT;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            deb_q   <= deb_d;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            press_q <= press_d;
            ent_q   <= ent_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign kp.entry_data  = data_q;
    assign kp.entry_valid = ent_q == SEND;
    assign kp.digit_cnt   = cnt_q;
    assign kp.err         = err_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: keystroke-level reference model driving directed and random key sequences
module tb_keypad_entry_ctrl;
    localparam int S   = 4;
    localparam int D   = 4;
    localparam int TO  = 100;
    localparam int MOD = 1 << (4 * D);

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    int   n_chk     = 0;
    int   n_fail    = 0;
    int   err_seen  = 0;
    int   tmo_seen  = 0;
    int   both_seen = 0;
    int   m_val     = 0;
    int   m_cnt     = 0;
    int   m_err     = 0;
    int   m_tmo     = 0;
    bit   m_valid   = 1'b0;
    bit   held      = 1'b0;
    logic [3:0] seq_a [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC};
    logic [3:0] seq_b [3] = '{4'h7, 4'hA, 4'hC};

    always #5 sys_clk = ~sys_clk;

    keypad_entry_ctrl_if #(.DIGITS(D)) kp ();

    keypad_entry_ctrl #(.DIGITS(D), .STABLE_CYC(S), .TIMEOUT_CYC(TO)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .kp       (kp)
    );

    // Count status pulses just after each edge
    always @(posedge sys_clk) begin
        #1;
        err_seen += int'(kp.err);
        tmo_seen += int'(kp.timeout);
        if (kp.err && kp.timeout) both_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] k, input bit rdy);
        kp.key_code    = k;
        kp.entry_ready = rdy;
        @(negedge sys_clk);
    endtask

    // What one qualified press does to the entry buffer
    task automatic model_press(input logic [3:0] c);
        if (m_valid) return;
        if (c <= 4'h9 || c == 4'hB) begin
            if (m_cnt == D) m_err++;
            else begin
                m_val = (m_val * 16 + (c == 4'hB ? 0 : int'(c))) % MOD;
                m_cnt++;
            end
        end else if (c == 4'hA) begin
            m_val = 0;
            m_cnt = 0;
        end else if (m_cnt == 0) m_err++;
        else m_valid = 1'b1;
    endtask

    task automatic model_xfer();
        if (m_valid) begin
            m_valid = 1'b0;
            m_val   = 0;
            m_cnt   = 0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "/digit_cnt"}, kp.digit_cnt, m_cnt);
        check({tag, "/entry_data"}, kp.entry_data, m_val);
        check({tag, "/entry_valid"}, kp.entry_valid, m_valid);
        check({tag, "/err_total"}, err_seen, m_err);
    endtask

    // Hold a code h cycles, then no key r cycles with ready raised on the last one
    task automatic stroke(input logic [3:0] c, input int h, input int r, input bit rdy);
        bit real_key = c >= 4'h1 && c <= 4'hC;
        bit p = real_key && !held && h >= S;
        if (p) model_press(c);
        held = real_key ? ((p || held) && r < S) : (held && h + r < S);
        repeat (h) cyc(c, 1'b0);
        repeat (r - 1) cyc(4'hF, 1'b0);
        cyc(4'hF, rdy);
        kp.entry_ready = 1'b0;
        if (rdy) model_xfer();
        check_state($sformatf("key_%0h", c));
    endtask

    task automatic release_ready(input int n);
        repeat (n - 1) cyc(4'hF, 1'b0);
        cyc(4'hF, 1'b1);
        kp.entry_ready = 1'b0;
        held = held && n < S;
        model_xfer();
        check_state("ready");
    endtask

    initial begin
        kp.key_code    = 4'hF;
        kp.entry_ready = 1'b0;
        #2 sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("rst/entry_data", kp.entry_data, 0);
        check("rst/entry_valid", kp.entry_valid, 0);
        check("rst/digit_cnt", kp.digit_cnt, 0);
        check("rst/err", kp.err, 0);
        check("rst/timeout", kp.timeout, 0);
        sys_rst_n = 1'b1;
        stroke(4'h5, 10, 10, 1'b0);
        check("single_press_digit", kp.entry_data[3:0], 4'h5);
        stroke(4'hA, 6, 6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(4'h3, 1'b0);
            cyc(4'h3, 1'b0);
            cyc(4'hF, 1'b0);
            cyc(4'hF, 1'b0);
        end
        check_state("glitch");
        foreach (seq_a[i]) stroke(seq_a[i], 6, 6, 1'b0);
        check("full_entry_data", kp.entry_data, 16'h1234);
        check("full_entry_valid", kp.entry_valid, 1);
        stroke(4'h9, 6, 6, 1'b0);
        check("send_hold_data", kp.entry_data, 16'h1234);
        release_ready(3);
        check("after_xfer_cnt", kp.digit_cnt, 0);
        foreach (seq_b[i]) stroke(seq_b[i], 6, 6, 1'b0);
        check("clear_then_enter_valid", kp.entry_valid, 0);
        stroke(4'hD, 8, 6, 1'b0);
        stroke(4'h2, 6, 6, 1'b0);
        cyc(4'h5, 1'b0);
        cyc(4'h5, 1'b0);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst/digit_cnt", kp.digit_cnt, 0);
        check("async_rst/entry_data", kp.entry_data, 0);
        m_val   = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        held    = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (S) cyc(4'h5, 1'b0);
        check("held_through_rst_early", kp.digit_cnt, 0);
        repeat (2) cyc(4'h5, 1'b0);
        repeat (S + 2) cyc(4'hF, 1'b0);
        model_press(4'h5);
        check_state("held_through_rst");
        stroke(4'hA, 6, 6, 1'b0);
        stroke(4'h8, 6, 6, 1'b0);
        repeat (TO) cyc(4'hF, 1'b0);
`ifdef KEYPAD_TIMEOUT_EN
        m_val = 0;
        m_cnt = 0;
        m_tmo++;
        check("timeout_digit_cnt", kp.digit_cnt, 0);
`else
        check("timeout_digit_cnt", kp.digit_cnt, 1);
`endif
        check("timeout_pulses", tmo_seen, m_tmo);
        for (int i = 0; i < 150; i++) begin
            logic [3:0] c;
            int h, r;
            c = 4'($urandom_range(12, 1));
`ifdef KEYPAD_TIMEOUT_EN
            h = $urandom_range(2 * S, S);
            r = $urandom_range(2 * S, S);
`else
            h = $urandom_range(2 * S, 1);
            r = $urandom_range(2 * S, 2);
`endif
            stroke(c, h, r, $urandom_range(3) == 0);
        end
        check("err_timeout_exclusive", both_seen, 0);
        check("timeout_total", tmo_seen, m_tmo);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
